// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control path: forwarding selects,
// ALU operation codes and the decoder control bundle carried down the pipe.
package mips_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SUB   = 3'b001;
  localparam logic [2:0] ALU_OP_AND   = 3'b010;
  localparam logic [2:0] ALU_OP_OR    = 3'b011;
  localparam logic [2:0] ALU_OP_SLT   = 3'b100;
  localparam logic [2:0] ALU_OP_FUNCT = 3'b111;

  // Decoder controls that travel with an instruction; jump is consumed in ID and not carried.
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_bundle_t;

  // Strip every architecturally visible side effect from a bundle.
  function automatic ctrl_bundle_t kill_side_effects(ctrl_bundle_t c);
    ctrl_bundle_t r;
    r            = c;
    r.mem_to_reg = 1'b0;
    r.reg_write  = 1'b0;
    r.mem_read   = 1'b0;
    r.mem_write  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX operand forwarding select: picks MEM over WB over the register file, never for $0.
module forward_unit
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  wb_valid,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
);

  logic mem_src_ok;
  logic wb_src_ok;

  always_comb begin
    mem_src_ok = mem_valid & mem_reg_write & (mem_dest != '0);
    wb_src_ok  = wb_valid & wb_reg_write & (wb_dest != '0);
  end

  always_comb begin
    forward_a = FWD_RF;
    if (mem_src_ok && (mem_dest == ex_rs)) begin
      forward_a = FWD_MEM;
    end else if (wb_src_ok && (wb_dest == ex_rs)) begin
      forward_a = FWD_WB;
    end
  end

  always_comb begin
    forward_b = FWD_RF;
    if (mem_src_ok && (mem_dest == ex_rt)) begin
      forward_b = FWD_MEM;
    end else if (wb_src_ok && (wb_dest == ex_rt)) begin
      forward_b = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Pipeline control registers ID->EX->MEM->WB with load-use stall, branch/jump flush,
// operand forwarding selects and a saturating stall-cycle counter.
module id_ex_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned ALU_OP_W    = 3,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic                   id_reg_dst,
  input  logic                   id_alu_src,
  input  logic                   id_mem_to_reg,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_mem_write,
  input  logic                   id_branch,
  input  logic                   id_jump,
  input  logic [ALU_OP_W-1:0]    id_alu_op,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   ex_branch_taken,
  output logic                   ex_valid,
  output logic                   ex_alu_src,
  output logic                   ex_branch,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_mem_to_reg,
  output logic                   ex_reg_write,
  output logic [ALU_OP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0]  ex_rs,
  output logic [REG_ADDR_W-1:0]  ex_rt,
  output logic [REG_ADDR_W-1:0]  ex_dest,
  output logic                   mem_valid,
  output logic                   mem_mem_read,
  output logic                   mem_mem_write,
  output logic                   mem_mem_to_reg,
  output logic                   mem_reg_write,
  output logic [REG_ADDR_W-1:0]  mem_dest,
  output logic                   wb_valid,
  output logic                   wb_mem_to_reg,
  output logic                   wb_reg_write,
  output logic [REG_ADDR_W-1:0]  wb_dest,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // EX stage
  logic                  ex_valid_q, ex_valid_d;
  ctrl_bundle_t          ex_ctrl_q, ex_ctrl_d;
  logic [ALU_OP_W-1:0]   ex_alu_op_q, ex_alu_op_d;
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;

  // MEM stage
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_mem_read_q, mem_mem_read_d;
  logic                  mem_mem_write_q, mem_mem_write_d;
  logic                  mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;

  // WB stage
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;

  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  ctrl_bundle_t          id_ctrl;
  logic [REG_ADDR_W-1:0] ex_dest_w;
  logic                  id_uses_rt;
  logic                  load_use;
  logic                  stall;
  logic                  ex_bubble;

  always_comb begin
    id_ctrl.reg_dst    = id_reg_dst;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.branch     = id_branch;
  end

  always_comb begin
    ex_dest_w  = ex_ctrl_q.reg_dst ? ex_rd_q : ex_rt_q;
    id_uses_rt = id_reg_dst | id_mem_write | id_branch;
    load_use   = ex_valid_q & ex_ctrl_q.mem_read & (ex_dest_w != '0) & id_valid &
                 ((ex_dest_w == id_rs) | (id_uses_rt & (ex_dest_w == id_rt)));
    // A taken branch flushes ID anyway, so holding the front end would be pointless.
    stall      = load_use & ~ex_branch_taken;
    ex_bubble  = ex_branch_taken | load_use | ~id_valid;
  end

  always_comb begin
    pc_write   = ~stall;
    ifid_write = ~stall;
    ifid_flush = ex_branch_taken | (id_jump & id_valid & ~load_use);
  end

  always_comb begin
    ex_valid_d  = ~ex_bubble;
    ex_ctrl_d   = '0;
    ex_alu_op_d = '0;
    ex_rs_d     = '0;
    ex_rt_d     = '0;
    ex_rd_d     = '0;
    if (!ex_bubble) begin
      ex_ctrl_d   = id_jump ? kill_side_effects(id_ctrl) : id_ctrl;
      ex_alu_op_d = id_alu_op;
      ex_rs_d     = id_rs;
      ex_rt_d     = id_rt;
      ex_rd_d     = id_rd;
    end
  end

  always_comb begin
    mem_valid_d      = ex_valid_q;
    mem_mem_read_d   = ex_valid_q & ex_ctrl_q.mem_read;
    mem_mem_write_d  = ex_valid_q & ex_ctrl_q.mem_write;
    mem_mem_to_reg_d = ex_valid_q & ex_ctrl_q.mem_to_reg;
    mem_reg_write_d  = ex_valid_q & ex_ctrl_q.reg_write;
    mem_dest_d       = ex_dest_w;

    wb_valid_d       = mem_valid_q;
    wb_mem_to_reg_d  = mem_valid_q & mem_mem_to_reg_q;
    wb_reg_write_d   = mem_valid_q & mem_reg_write_q;
    wb_dest_d        = mem_dest_q;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q       <= 1'b0;
      ex_ctrl_q        <= '0;
      ex_alu_op_q      <= '0;
      ex_rs_q          <= '0;
      ex_rt_q          <= '0;
      ex_rd_q          <= '0;
      mem_valid_q      <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_dest_q       <= '0;
      wb_valid_q       <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_dest_q        <= '0;
      stall_count_q    <= '0;
    end else begin
      ex_valid_q       <= ex_valid_d;
      ex_ctrl_q        <= ex_ctrl_d;
      ex_alu_op_q      <= ex_alu_op_d;
      ex_rs_q          <= ex_rs_d;
      ex_rt_q          <= ex_rt_d;
      ex_rd_q          <= ex_rd_d;
      mem_valid_q      <= mem_valid_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_dest_q       <= mem_dest_d;
      wb_valid_q       <= wb_valid_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_dest_q        <= wb_dest_d;
      stall_count_q    <= stall_count_d;
    end
  end

  always_comb begin
    ex_valid       = ex_valid_q;
    ex_alu_src     = ex_ctrl_q.alu_src;
    ex_branch      = ex_ctrl_q.branch;
    ex_mem_read    = ex_ctrl_q.mem_read;
    ex_mem_write   = ex_ctrl_q.mem_write;
    ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
    ex_reg_write   = ex_ctrl_q.reg_write;
    ex_alu_op      = ex_alu_op_q;
    ex_rs          = ex_rs_q;
    ex_rt          = ex_rt_q;
    ex_dest        = ex_dest_w;
    mem_valid      = mem_valid_q;
    mem_mem_read   = mem_mem_read_q;
    mem_mem_write  = mem_mem_write_q;
    mem_mem_to_reg = mem_mem_to_reg_q;
    mem_reg_write  = mem_reg_write_q;
    mem_dest       = mem_dest_q;
    wb_valid       = wb_valid_q;
    wb_mem_to_reg  = wb_mem_to_reg_q;
    wb_reg_write   = wb_reg_write_q;
    wb_dest        = wb_dest_q;
    stall_count    = stall_count_q;
  end

  forward_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_forward_unit (
    .mem_valid    (mem_valid_q),
    .mem_reg_write(mem_reg_write_q),
    .mem_dest     (mem_dest_q),
    .wb_valid     (wb_valid_q),
    .wb_reg_write (wb_reg_write_q),
    .wb_dest      (wb_dest_q),
    .ex_rs        (ex_rs_q),
    .ex_rt        (ex_rt_q),
    .forward_a    (forward_a),
    .forward_b    (forward_b)
  );

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl; a 4-bit stall counter keeps the saturation run short.
module tb_id_ex_hazard_ctrl;

  localparam int CW = 4;
  localparam int AW = 5;
  localparam int OW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
  logic          id_mem_read, id_mem_write, id_branch, id_jump;
  logic [OW-1:0] id_alu_op;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          ex_branch_taken;
  logic          ex_valid, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write;
  logic          ex_mem_to_reg, ex_reg_write;
  logic [OW-1:0] ex_alu_op;
  logic [AW-1:0] ex_rs, ex_rt, ex_dest;
  logic          mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [AW-1:0] mem_dest;
  logic          wb_valid, wb_mem_to_reg, wb_reg_write;
  logic [AW-1:0] wb_dest;
  logic          pc_write, ifid_write, ifid_flush;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] exp_cnt;

  id_ex_hazard_ctrl #(
    .REG_ADDR_W (AW),
    .ALU_OP_W   (OW),
    .STALL_CNT_W(CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_reg_dst     (id_reg_dst),
    .id_alu_src     (id_alu_src),
    .id_mem_to_reg  (id_mem_to_reg),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .id_branch      (id_branch),
    .id_jump        (id_jump),
    .id_alu_op      (id_alu_op),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_valid       (ex_valid),
    .ex_alu_src     (ex_alu_src),
    .ex_branch      (ex_branch),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_reg_write   (ex_reg_write),
    .ex_alu_op      (ex_alu_op),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_dest        (ex_dest),
    .mem_valid      (mem_valid),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_reg_write  (mem_reg_write),
    .mem_dest       (mem_dest),
    .wb_valid       (wb_valid),
    .wb_mem_to_reg  (wb_mem_to_reg),
    .wb_reg_write   (wb_reg_write),
    .wb_dest        (wb_dest),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .stall_count    (stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_reg_dst = 0; id_alu_src = 0; id_mem_to_reg = 0; id_reg_write = 0;
    id_mem_read = 0; id_mem_write = 0; id_branch = 0; id_jump = 0;
    id_alu_op = '0; id_rs = '0; id_rt = '0; id_rd = '0;
  endtask

  task automatic set_lw(input logic [AW-1:0] rt, input logic [AW-1:0] rs);
    clr_id();
    id_valid = 1; id_alu_src = 1; id_mem_to_reg = 1; id_reg_write = 1; id_mem_read = 1;
    id_rs = rs; id_rt = rt;
  endtask

  task automatic set_r(input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt);
    clr_id();
    id_valid = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = 3'b111;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic set_beq(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    clr_id();
    id_valid = 1; id_branch = 1; id_alu_op = 3'b001; id_rs = rs; id_rt = rt;
  endtask

  task automatic drain();
    clr_id();
    ex_branch_taken = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    set_r(5'd1, 5'd2, 5'd3); tick();
    set_r(5'd4, 5'd5, 5'd6); tick();
    set_r(5'd7, 5'd8, 5'd9); tick();
    checks++; if (wb_valid !== 1'b1 || wb_dest !== 5'd1 || wb_reg_write !== 1'b1) begin
      failures++; $display("FAIL latency_wb got v=%0b d=%0d rw=%0b exp v=1 d=1 rw=1",
                           wb_valid, wb_dest, wb_reg_write); end
    reset = 1; tick(); reset = 0; clr_id(); #1;
    checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_valids got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
    checks++; if (stall_count !== '0) begin
      failures++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
    checks++; if ({pc_write, ifid_write, ifid_flush} !== 3'b110) begin
      failures++; $display("FAIL reset_frontend got=%b exp=110", {pc_write, ifid_write, ifid_flush}); end
    checks++; if ({forward_a, forward_b} !== 4'b0000) begin
      failures++; $display("FAIL reset_forward got=%b exp=0000", {forward_a, forward_b}); end
    checks++; if (mem_dest !== '0 || wb_dest !== '0 || ex_dest !== '0) begin
      failures++; $display("FAIL reset_dests got=%0d/%0d/%0d exp=0/0/0", ex_dest, mem_dest, wb_dest); end
  endtask

  task automatic test_load_use();
    set_lw(5'd8, 5'd9); tick();
    set_r(5'd10, 5'd8, 5'd11); #1;
    checks++; if ({pc_write, ifid_write} !== 2'b00) begin
      failures++; $display("FAIL lu_stall got=%b exp=00", {pc_write, ifid_write}); end
    tick();
    checks++; if ({pc_write, ifid_write} !== 2'b11) begin
      failures++; $display("FAIL lu_one_cycle got=%b exp=11", {pc_write, ifid_write}); end
    checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b1 || mem_dest !== 5'd8) begin
      failures++; $display("FAIL lu_bubble got exv=%0b memv=%0b md=%0d exp 0 1 8",
                           ex_valid, mem_valid, mem_dest); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_dest !== 5'd10) begin
      failures++; $display("FAIL lu_add_in_ex got v=%0b rs=%0d dest=%0d exp 1 8 10",
                           ex_valid, ex_rs, ex_dest); end
    checks++; if (forward_a !== 2'b01 || forward_b !== 2'b00) begin
      failures++; $display("FAIL lu_forward got=%b/%b exp=01/00", forward_a, forward_b); end
    checks++; if (stall_count !== 4'd1) begin
      failures++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
    drain();
  endtask

  task automatic test_forwarding();
    set_r(5'd8, 5'd1, 5'd2); tick();
    set_r(5'd3, 5'd8, 5'd8); #1;
    checks++; if (pc_write !== 1'b1) begin
      failures++; $display("FAIL fw_no_stall got=%0b exp=1", pc_write); end
    tick();
    checks++; if (forward_a !== 2'b10 || forward_b !== 2'b10) begin
      failures++; $display("FAIL fw_mem got=%b/%b exp=10/10", forward_a, forward_b); end
    set_r(5'd8, 5'd8, 5'd0); tick();
    checks++; if (forward_a !== 2'b01 || forward_b !== 2'b00) begin
      failures++; $display("FAIL fw_wb got=%b/%b exp=01/00", forward_a, forward_b); end
    drain();
    // Two producers of $8 in flight: the younger one in MEM must win.
    set_r(5'd8, 5'd1, 5'd2); tick();
    set_r(5'd8, 5'd3, 5'd4); tick();
    set_r(5'd5, 5'd8, 5'd8); tick();
    checks++; if (forward_a !== 2'b10 || forward_b !== 2'b10) begin
      failures++; $display("FAIL fw_priority got=%b/%b exp=10/10", forward_a, forward_b); end
    drain();
  endtask

  task automatic test_zero_reg();
    set_lw(5'd0, 5'd1); tick();
    set_r(5'd2, 5'd0, 5'd0); #1;
    checks++; if ({pc_write, ifid_write} !== 2'b11) begin
      failures++; $display("FAIL zero_no_stall got=%b exp=11", {pc_write, ifid_write}); end
    tick();
    checks++; if (ex_valid !== 1'b1 || forward_a !== 2'b00 || forward_b !== 2'b00) begin
      failures++; $display("FAIL zero_forward got v=%0b fa=%b fb=%b exp 1 00 00",
                           ex_valid, forward_a, forward_b); end
    drain();
  endtask

  task automatic test_branch_flush();
    set_beq(5'd1, 5'd2); tick();
    set_r(5'd10, 5'd8, 5'd11); ex_branch_taken = 1; #1;
    checks++; if ({ifid_flush, pc_write, ifid_write} !== 3'b111) begin
      failures++; $display("FAIL br_frontend got=%b exp=111", {ifid_flush, pc_write, ifid_write}); end
    tick(); ex_branch_taken = 0; clr_id();
    checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b1 || mem_reg_write !== 1'b0) begin
      failures++; $display("FAIL br_advance got exv=%0b memv=%0b mrw=%0b exp 0 1 0",
                           ex_valid, mem_valid, mem_reg_write); end
    drain();
    // Taken branch coinciding with a load-use pattern: flush, no stall.
    set_lw(5'd8, 5'd9); tick();
    set_r(5'd10, 5'd8, 5'd11); ex_branch_taken = 1; #1;
    checks++; if ({ifid_flush, pc_write, ifid_write} !== 3'b111) begin
      failures++; $display("FAIL br_lu_frontend got=%b exp=111", {ifid_flush, pc_write, ifid_write}); end
    tick(); ex_branch_taken = 0; clr_id();
    checks++; if (ex_valid !== 1'b0 || stall_count !== 4'd1) begin
      failures++; $display("FAIL br_lu_count got v=%0b cnt=%0d exp 0 1", ex_valid, stall_count); end
    drain();
  endtask

  task automatic test_jump_and_bubble();
    clr_id(); id_valid = 1; id_jump = 1; id_reg_write = 1; id_mem_write = 1; #1;
    checks++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin
      failures++; $display("FAIL jump_flush got fl=%0b pc=%0b exp 1 1", ifid_flush, pc_write); end
    tick(); clr_id(); #1;
    checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin
      failures++; $display("FAIL jump_ex got v=%0b rw=%0b mw=%0b exp 1 0 0",
                           ex_valid, ex_reg_write, ex_mem_write); end
    id_reg_write = 1; id_mem_read = 1; tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      failures++; $display("FAIL invalid_bubble got v=%0b rw=%0b mr=%0b exp 0 0 0",
                           ex_valid, ex_reg_write, ex_mem_read); end
    drain();
  endtask

  task automatic test_stall_saturate();
    exp_cnt = stall_count;
    for (int i = 0; i < 20; i++) begin
      set_lw(5'd8, 5'd9); tick();
      set_r(5'd10, 5'd8, 5'd11); #1;
      checks++; if (pc_write !== 1'b0) begin
        failures++; $display("FAIL sat_stall_%0d got=%0b exp=0", i, pc_write); end
      tick();
      if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      if (i == 12) begin
        checks++; if (stall_count !== 4'd14) begin
          failures++; $display("FAIL sat_mid got=%0d exp=14", stall_count); end
      end
    end
    checks++; if (stall_count !== 4'hF || stall_count !== exp_cnt) begin
      failures++; $display("FAIL sat_hold got=%0d exp=%0d", stall_count, exp_cnt); end
    drain();
  endtask

  initial begin
    reset = 1; ex_branch_taken = 0; clr_id();
    tick(); tick();
    reset = 0;
    test_reset();
    test_load_use();
    test_forwarding();
    test_zero_reg();
    test_branch_flush();
    test_jump_and_bubble();
    test_stall_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
